cordic_prerotator: RTL and testbench
====================================

Name: cordic_prerotator

Overview:
Upstream feeder for the 12-stage Q5.11 CORDIC rotator. It accepts a stream of complex samples and generates a per-sample phase from a wrapping phase accumulator over a framed run. It folds each phase into the rotator's convergence range (|theta| <= pi/2) by negating the sample. It then presents a registered x/y/theta triple with a valid/ready handshake.

Parameters:
WIDTH, 16, sample and phase width; all values are signed Q5.11.
CNT_W, 10, width of the frame-length counter.
PI_Q, 6434, pi in Q5.11.
HALF_PI_Q, 3217, pi/2 in Q5.11.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  pulse; begins a frame. Ignored unless the block is IDLE.
frame_len  in  CNT_W  samples per frame; sampled on start; 0 is treated as 1.
phase_init  in  WIDTH  starting phase; sampled on start; must lie in [-PI_Q, PI_Q).
phase_inc  in  WIDTH  per-sample phase step; sampled on start; |phase_inc| <= PI_Q.
in_valid  in  1  input sample valid.
in_ready  out  1  block can accept a sample.
x_in, y_in  in  WIDTH each  input sample.
out_valid  out  1  output triple valid.
out_ready  in  1  downstream accepts.
x_out, y_out, theta_out  out  WIDTH each  folded sample and residual angle.
busy  out  1  high when not IDLE.
done  out  1  one-cycle pulse after the last output handshake of a frame.

Behaviour:
- Reset (async, rst=1): state=IDLE; acc=0; remaining count=0.
- Reset values: in_ready=0, out_valid=0, x_out=y_out=theta_out=0, busy=0, done=0.
- States:
  - IDLE -> RUN on start: latch frame_len (0 -> 1), acc=phase_init, latch phase_inc.
  - RUN: in_ready = (!out_valid || out_ready).
    - Input accept = in_valid && in_ready.
    - On accept: load the output register, acc <= wrap(acc + phase_inc), decrement remaining.
    - Accepting the last sample -> DRAIN.
  - DRAIN: in_ready=0. When the output handshake of the final triple occurs, pulse done for one cycle and go to IDLE.
  - A start pulse outside IDLE is ignored.
- Wrap of acc: compute the sum at WIDTH+1 bits.
  - If sum >= PI_Q, subtract 2*PI_Q.
  - If sum < -PI_Q, add 2*PI_Q.
  - acc always stays in [-PI_Q, PI_Q).
- Fold, applied to the current acc at accept (t = acc):
  - t > HALF_PI_Q: x=-x_in, y=-y_in, theta=t-PI_Q.
  - t < -HALF_PI_Q: x=-x_in, y=-y_in, theta=t+PI_Q.
  - Otherwise: pass-through, theta=t.
  - t == +/-HALF_PI_Q is not folded.
- Negation saturates: -(-32768) -> 32767.
- Latency: one cycle from input accept to out_valid.
- Throughput: one sample per cycle while out_ready=1.
- Output register holds its value while out_valid && !out_ready.
- Simultaneous output handshake and input accept in the same cycle: the register reloads and out_valid stays 1.
- out_valid clears on a handshake with no new accept.
- Reset mid-frame: everything returns to reset values immediately. The in-flight sample is dropped and no done pulse is issued.

Optional Feature:
Macro CORDIC_PREROT_STATS_EN.
- Defined:
  - Adds output fold_cnt (16 bits): the number of folded samples accepted in the current frame.
  - Cleared on start and on reset; saturates at 16'hFFFF.
  - Its value is held after done until the next start.
- Undefined: no fold_cnt port and no counter logic; behaviour is otherwise identical.

Decomposition:
- Shared package cordic_pkg holds:
  - the Q5.11 constants PI_Q, HALF_PI_Q and TWO_PI_Q (12868);
  - the state enum IDLE/RUN/DRAIN;
  - a saturating-negate function.
- One sub-module, cordic_quadrant_fold: purely combinational fold of (x, y, t) to (x', y', theta'), reusable by a future vectoring-mode block.
- Phase accumulator, FSM and output register live in the top module.

Test Plan:
- start with frame_len=4, phase_init=0, phase_inc=1608, out_ready=1, 4 back-to-back samples (x=1000, y=0):
  - theta_out = 0, 1608, 3216, -1610 (3216+1608=4824 folds to 4824-6434);
  - the fourth triple is x=-1000, y=0;
  - done pulses the cycle after the fourth handshake.
- phase_init=6000, phase_inc=1000:
  - first theta = 6000-6434 = -434, folded;
  - acc wraps to 7000-12868 = -5868; second theta = -5868+6434 = 566, folded.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1. Required: in_ready=0 and x/y/theta_out stable; after release, no sample lost or duplicated.
- x_in=-32768, y_in=-32768 with a folded phase -> x_out=y_out=32767; with STATS_EN, fold_cnt increments.
- Assert rst mid-frame after 2 of 5 samples -> outputs go to reset values in the same cycle, no done pulse; the next start runs a clean frame.
- frame_len=0 with start -> exactly one sample processed, then done.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared Q5.11 constants, FSM state type and saturating negate for the CORDIC front end.
package cordic_pkg;

  localparam int Q_W       = 16;
  localparam int PI_Q      = 6434;
  localparam int HALF_PI_Q = 3217;
  localparam int TWO_PI_Q  = 12868;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  // The most negative code has no positive twin; clamp it to the largest positive.
  function automatic logic signed [Q_W-1:0] sat_neg(input logic signed [Q_W-1:0] v);
    return (v == {1'b1, {(Q_W-1){1'b0}}}) ? {1'b0, {(Q_W-1){1'b1}}} : -v;
  endfunction

endpackage

// File: rtl/cordic_quadrant_fold.sv
// Folds (x, y, t) into |theta| <= pi/2 by negating the sample and shifting the angle by pi.
module cordic_quadrant_fold import cordic_pkg::*; #(
  parameter int WIDTH     = Q_W,
  parameter int PI_V      = cordic_pkg::PI_Q,
  parameter int HALF_PI_V = cordic_pkg::HALF_PI_Q
)(
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] t,
  output logic signed [WIDTH-1:0] x_fold,
  output logic signed [WIDTH-1:0] y_fold,
  output logic signed [WIDTH-1:0] theta,
  output logic                    folded
);

  always_comb begin
    x_fold = x;
    y_fold = y;
    theta  = t;
    folded = 1'b0;
    if (t > HALF_PI_V) begin
      x_fold = sat_neg(x);
      y_fold = sat_neg(y);
      theta  = WIDTH'(t - PI_V);
      folded = 1'b1;
    end else if (t < -HALF_PI_V) begin
      x_fold = sat_neg(x);
      y_fold = sat_neg(y);
      theta  = WIDTH'(t + PI_V);
      folded = 1'b1;
    end
  end

endmodule

// File: rtl/cordic_prerotator.sv
// Framed phase accumulator + quadrant fold feeding the CORDIC rotator through a registered
// valid/ready stage. CORDIC_PREROT_STATS_EN adds a per-frame fold counter output.
module cordic_prerotator import cordic_pkg::*; #(
  parameter int WIDTH     = 16,
  parameter int CNT_W     = 10,
  parameter int PI_Q      = cordic_pkg::PI_Q,
  parameter int HALF_PI_Q = cordic_pkg::HALF_PI_Q
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        frame_len,
  input  logic signed [WIDTH-1:0] phase_init,
  input  logic signed [WIDTH-1:0] phase_inc,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] theta_out,
  output logic                    busy,
  output logic                    done
`ifdef CORDIC_PREROT_STATS_EN
  , output logic [15:0]           fold_cnt
`endif
);

  state_e                  state, state_nxt;
  logic [CNT_W-1:0]        remaining;
  logic signed [WIDTH-1:0] acc, inc;
  logic signed [WIDTH:0]   sum, wrapped;
  logic signed [WIDTH-1:0] fx, fy, ft;
  logic                    folded, accept, hs, last, launch;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid && out_ready;
  assign last     = (remaining == CNT_W'(1));
  assign launch   = (state == IDLE) && start;
  assign busy     = (state != IDLE);

  // One extra bit so the sum of two in-range phases cannot overflow before wrapping.
  always_comb begin
    sum     = (WIDTH+1)'(acc) + (WIDTH+1)'(inc);
    wrapped = sum;
    if (sum >= (WIDTH+1)'(PI_Q))
      wrapped = sum - (WIDTH+1)'(2*PI_Q);
    else if (sum < -(WIDTH+1)'(PI_Q))
      wrapped = sum + (WIDTH+1)'(2*PI_Q);
  end

  cordic_quadrant_fold #(
    .WIDTH(WIDTH), .PI_V(PI_Q), .HALF_PI_V(HALF_PI_Q)
  ) u_fold (
    .x(x_in), .y(y_in), .t(acc),
    .x_fold(fx), .y_fold(fy), .theta(ft), .folded(folded)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)          state_nxt = RUN;
      RUN:     if (accept && last) state_nxt = DRAIN;
      DRAIN:   if (hs)             state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      inc       <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      theta_out <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == DRAIN) && hs;
      if (launch) begin
        acc       <= phase_init;
        inc       <= phase_inc;
        remaining <= (frame_len == '0) ? CNT_W'(1) : frame_len;
      end else if (accept) begin
        acc       <= wrapped[WIDTH-1:0];
        remaining <= remaining - CNT_W'(1);
      end
      // A reload wins over a same-cycle handshake so back-to-back samples keep out_valid high.
      if (accept) begin
        out_valid <= 1'b1;
        x_out     <= fx;
        y_out     <= fy;
        theta_out <= ft;
      end else if (hs) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CORDIC_PREROT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       fold_cnt <= '0;
    else if (launch)                               fold_cnt <= '0;
    else if (accept && folded && fold_cnt != 16'hFFFF) fold_cnt <= fold_cnt + 16'd1;
  end
`else
  logic unused_folded;
  assign unused_folded = folded;
`endif

endmodule

// File: tb/tb_cordic_prerotator.sv
// Scoreboard bench for cordic_prerotator: an independent phase/fold model queues expected triples.
module tb_cordic_prerotator;

  localparam int WIDTH = 16;
  localparam int CNT_W = 10;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [CNT_W-1:0]        frame_len = '0;
  logic signed [WIDTH-1:0] phase_init = '0, phase_inc = '0;
  logic                    in_valid = 1'b0, in_ready;
  logic signed [WIDTH-1:0] x_in = '0, y_in = '0;
  logic                    out_valid, out_ready = 1'b1;
  logic signed [WIDTH-1:0] x_out, y_out, theta_out;
  logic                    busy, done;
`ifdef CORDIC_PREROT_STATS_EN
  logic [15:0]             fold_cnt;
`endif

  cordic_prerotator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .phase_init(phase_init), .phase_inc(phase_inc),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .theta_out(theta_out),
    .busy(busy), .done(done)
`ifdef CORDIC_PREROT_STATS_EN
    , .fold_cnt(fold_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; int t;} trip_t;
  trip_t exp_q[$];

  int checks = 0, errors = 0;
  int m_acc = 0, m_inc = 0, m_folds = 0, exp_left = 0;
  bit exp_done = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int sneg(input int v);
    return (v == -32768) ? 32767 : -v;
  endfunction

  task automatic push_expected(input int x, input int y);
    trip_t e;
    if (m_acc > 3217) begin
      e = '{sneg(x), sneg(y), m_acc - 6434}; m_folds++;
    end else if (m_acc < -3217) begin
      e = '{sneg(x), sneg(y), m_acc + 6434}; m_folds++;
    end else begin
      e = '{x, y, m_acc};
    end
    exp_q.push_back(e);
    m_acc = m_acc + m_inc;
    if (m_acc >= 6434)       m_acc -= 12868;
    else if (m_acc < -6434)  m_acc += 12868;
  endtask

  task automatic send(input int x, input int y);
    int n;
    n = 0;
    in_valid = 1'b1; x_in = 16'(x); y_in = 16'(y);
    @(negedge clk);
    while (!in_ready && n < 100) begin n++; @(negedge clk); end
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else           push_expected(x, y);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin n++; @(posedge clk); #1; end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  task automatic start_frame(input int len, input int init, input int inc);
    wait_idle();
    start = 1'b1; frame_len = CNT_W'(len); phase_init = 16'(init); phase_inc = 16'(inc);
    @(posedge clk); #1;
    start = 1'b0;
    m_acc = init; m_inc = inc; m_folds = 0;
    exp_left = (len == 0) ? 1 : len;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic end_frame();
    wait_idle();
    @(posedge clk); #1;
`ifdef CORDIC_PREROT_STATS_EN
    chk("fold_cnt", fold_cnt, m_folds);
`endif
  endtask

  always @(negedge clk) begin
    trip_t e;
    if (rst) begin
      exp_done = 1'b0;
    end else begin
      chk("done", done, exp_done);
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("x_out", x_out, e.x);
          chk("y_out", y_out, e.y);
          chk("theta_out", theta_out, e.t);
          exp_left--;
          if (exp_left == 0) exp_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_theta_out", theta_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back frame; fourth phase 4824 folds to -1610.
    start_frame(4, 0, 1608);
    repeat (4) send(1000, 0);
    end_frame();

    // Start past +pi/2, accumulator wraps through +pi.
    start_frame(2, 6000, 1000);
    send(300, -200);
    send(-50, 70);
    end_frame();

    // Backpressure with a stray start that must be ignored.
    start_frame(3, -3000, 500);
    send(11, 22);
    out_ready = 1'b0;
    in_valid = 1'b1; x_in = 16'sd33; y_in = 16'sd44;
    start = 1'b1; frame_len = 10'd7; phase_init = 16'sd100;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_x_hold", x_out, exp_q[0].x);
      chk("bp_theta_hold", theta_out, exp_q[0].t);
    end
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    send(33, 44);
    send(55, 66);
    end_frame();

    // Saturating negate on the most negative code.
    start_frame(2, 5000, 0);
    send(-32768, -32768);
    send(-32768, 5);
    end_frame();

    // Reset mid-frame after two of five samples.
    start_frame(5, 0, 100);
    send(1, 2);
    send(3, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_x_out", x_out, 0);
    chk("midrst_theta_out", theta_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_done", done, 0);
`ifdef CORDIC_PREROT_STATS_EN
    chk("midrst_fold_cnt", fold_cnt, 0);
`endif
    exp_q.delete();
    exp_left = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Boundaries: -pi folds to 0, -pi/2 and 0 pass through.
    start_frame(3, -6434, 3217);
    send(10, -20);
    send(30, -40);
    send(50, -60);
    end_frame();

    // frame_len = 0 behaves as a single-sample frame.
    start_frame(0, 1234, 0);
    send(7, 8);
    end_frame();
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
